// File: rtl/bip_control.sv
// bip_control: single-cycle control unit for the BIP accumulator datapath.
// Ports: i_clk, i_reset, i_start, i_Instruction -> o_PC, o_Operand, datapath selects/strobes, status.
module bip_control #(
  parameter int NBITS_PC  = 11,
  parameter int NBITS_OPC = 5,
  parameter int NBITS_O   = 11,
  parameter int NBITS_I   = 16,
  parameter int NBITS_CNT = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [NBITS_I-1:0]   i_Instruction,
  output logic [NBITS_PC-1:0]  o_PC,
  output logic [NBITS_O-1:0]   o_Operand,
  output logic [1:0]           o_SelA,
  output logic                 o_SelB,
  output logic                 o_WrAcc,
  output logic                 o_Op,
  output logic                 o_WrRam,
  output logic                 o_RdRam,
  output logic                 o_running,
  output logic                 o_halted,
  output logic [NBITS_CNT-1:0] o_instr_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [NBITS_OPC-1:0] OP_HLT  = NBITS_OPC'(0);
  localparam logic [NBITS_OPC-1:0] OP_STO  = NBITS_OPC'(1);
  localparam logic [NBITS_OPC-1:0] OP_LD   = NBITS_OPC'(2);
  localparam logic [NBITS_OPC-1:0] OP_LDI  = NBITS_OPC'(3);
  localparam logic [NBITS_OPC-1:0] OP_ADD  = NBITS_OPC'(4);
  localparam logic [NBITS_OPC-1:0] OP_ADDI = NBITS_OPC'(5);
  localparam logic [NBITS_OPC-1:0] OP_SUB  = NBITS_OPC'(6);
  localparam logic [NBITS_OPC-1:0] OP_SUBI = NBITS_OPC'(7);

  localparam logic [1:0] SELA_MEM = 2'b00;
  localparam logic [1:0] SELA_IMM = 2'b01;
  localparam logic [1:0] SELA_ALU = 2'b10;

  state_t                 state_q, state_d;
  logic [NBITS_PC-1:0]    pc_q, pc_d;
  logic [NBITS_CNT-1:0]   cnt_q, cnt_d;

  logic [NBITS_OPC-1:0]   opc;
  logic                   is_hlt;
  logic                   exec;

  assign opc    = i_Instruction[NBITS_I-1 -: NBITS_OPC];
  assign is_hlt = (opc == OP_HLT);

  // Decode only drives the datapath while running and not being reset,
  // so a reset cycle can never commit an ACC or memory write.
  assign exec = (state_q == S_RUN) && !i_reset;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) state_d = S_RUN;
      end
      S_RUN: begin
        if (is_hlt) begin
          state_d = S_HALT;
        end else begin
          // PC wraps naturally at the top of program memory.
          pc_d = pc_q + NBITS_PC'(1);
          if (cnt_q != '1) cnt_d = cnt_q + NBITS_CNT'(1);
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    o_SelA  = SELA_MEM;
    o_SelB  = 1'b0;
    o_WrAcc = 1'b0;
    o_Op    = 1'b0;
    o_WrRam = 1'b0;
    o_RdRam = 1'b0;
    if (exec) begin
      case (opc)
        OP_STO: begin
          o_WrRam = 1'b1;
        end
        OP_LD: begin
          o_RdRam = 1'b1;
          o_SelA  = SELA_MEM;
          o_WrAcc = 1'b1;
        end
        OP_LDI: begin
          o_SelA  = SELA_IMM;
          o_WrAcc = 1'b1;
        end
        OP_ADD: begin
          o_RdRam = 1'b1;
          o_SelA  = SELA_ALU;
          o_WrAcc = 1'b1;
        end
        OP_ADDI: begin
          o_SelB  = 1'b1;
          o_SelA  = SELA_ALU;
          o_WrAcc = 1'b1;
        end
        OP_SUB: begin
          o_RdRam = 1'b1;
          o_Op    = 1'b1;
          o_SelA  = SELA_ALU;
          o_WrAcc = 1'b1;
        end
        OP_SUBI: begin
          o_SelB  = 1'b1;
          o_Op    = 1'b1;
          o_SelA  = SELA_ALU;
          o_WrAcc = 1'b1;
        end
        default: begin
          // HLT and undefined opcodes leave every strobe low.
        end
      endcase
    end
  end

  assign o_PC          = pc_q;
  assign o_Operand     = i_Instruction[NBITS_O-1:0];
  assign o_running     = (state_q == S_RUN);
  assign o_halted      = (state_q == S_HALT);
  assign o_instr_count = cnt_q;

endmodule

// File: tb/tb_bip_control.sv
// Testbench for bip_control: program tables with a decode scoreboard,
// a small accumulator/data-memory model, and multi-cycle corner sequences.
module tb_bip_control;

  typedef struct {
    logic [10:0] pc;
    logic [15:0] ins;
    logic [1:0]  sela;
    logic        selb;
    logic        wracc;
    logic        op;
    logic        wrram;
    logic        rdram;
    logic [15:0] acc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] instr;
  logic [10:0] pc;
  logic [10:0] operand;
  logic [1:0]  sela;
  logic        selb, wracc, op, wrram, rdram, running, halted;
  logic [15:0] icnt;

  logic        w_rst = 1'b0;
  logic        w_start = 1'b0;
  logic [15:0] w_instr;
  logic [2:0]  w_pc;
  logic [10:0] w_operand;
  logic [1:0]  w_sela;
  logic        w_selb, w_wracc, w_op, w_wrram, w_rdram, w_running, w_halted;
  logic [15:0] w_icnt;

  logic [15:0] imem [0:2047];
  logic [15:0] dmem [0:2047];
  logic [15:0] acc;
  logic        pre_we = 1'b0;
  logic [10:0] pre_a = '0;
  logic [15:0] pre_d = '0;

  int n_cmp = 0;
  int n_err = 0;
  vec_t sb[$];
  vec_t prog_a[5];
  vec_t prog_b[4];
  vec_t prog_d[2];

  always #5 clk = ~clk;

  assign instr   = imem[pc];
  assign w_instr = 16'hF800;

  bip_control dut (
    .i_clk(clk), .i_reset(rst), .i_start(start),
    .i_Instruction(instr), .o_PC(pc), .o_Operand(operand),
    .o_SelA(sela), .o_SelB(selb), .o_WrAcc(wracc), .o_Op(op),
    .o_WrRam(wrram), .o_RdRam(rdram), .o_running(running),
    .o_halted(halted), .o_instr_count(icnt)
  );

  bip_control #(.NBITS_PC(3)) dut_w (
    .i_clk(clk), .i_reset(w_rst), .i_start(w_start),
    .i_Instruction(w_instr), .o_PC(w_pc), .o_Operand(w_operand),
    .o_SelA(w_sela), .o_SelB(w_selb), .o_WrAcc(w_wracc), .o_Op(w_op),
    .o_WrRam(w_wrram), .o_RdRam(w_rdram), .o_running(w_running),
    .o_halted(w_halted), .o_instr_count(w_icnt)
  );

  // Reference datapath driven by the control strobes.
  logic [15:0] ext, mrd, alu_b, alu;
  assign ext   = {{5{operand[10]}}, operand};
  assign mrd   = dmem[operand];
  assign alu_b = selb ? ext : mrd;
  assign alu   = op ? (acc - alu_b) : (acc + alu_b);

  always @(posedge clk) begin
    if (pre_we) dmem[pre_a] <= pre_d;
    if (rst) begin
      acc <= '0;
    end else begin
      if (wracc) begin
        case (sela)
          2'b00:   acc <= mrd;
          2'b01:   acc <= ext;
          default: acc <= alu;
        endcase
      end
      if (wrram) dmem[operand] <= acc;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [10:0] p, input logic [4:0] o, input logic [10:0] a,
                              input logic [1:0] sa, input logic sb_, input logic wa,
                              input logic op_, input logic wr, input logic rd, input logic [15:0] ac);
    vec_t v;
    v.pc = p; v.ins = {o, a}; v.sela = sa; v.selb = sb_; v.wracc = wa;
    v.op = op_; v.wrram = wr; v.rdram = rd; v.acc = ac;
    return v;
  endfunction

  task automatic poke(input logic [10:0] a, input logic [15:0] d);
    @(negedge clk);
    pre_a = a; pre_d = d; pre_we = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 16; i++) imem[i] = 16'h0000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_prog(input int budget);
    int cyc = 0;
    vec_t e;
    pulse_start();
    while (1) begin
      if (running) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'(pc), 32'hFFFF);
        end else begin
          e = sb.pop_front();
          chk($sformatf("decode@pc%0d", e.pc),
              {pc, sela, selb, wracc, op, wrram, rdram},
              {e.pc, e.sela, e.selb, e.wracc, e.op, e.wrram, e.rdram});
          chk($sformatf("operand@pc%0d", e.pc), 32'(operand), 32'(e.ins[10:0]));
          chk($sformatf("acc@pc%0d", e.pc), 32'(acc), 32'(e.acc));
        end
      end
      if (halted) break;
      if (cyc++ >= budget) begin
        chk("run_timeout", 32'(cyc), 32'(budget));
        break;
      end
      @(negedge clk);
    end
    chk("sb_leftover", 32'(sb.size()), 32'd0);
  endtask

  task automatic load(input vec_t v);
    imem[v.pc] = v.ins;
    sb.push_back(v);
  endtask

  initial begin
    int cyc;
    prog_a[0] = mk(0, 5'd3, 11'd5,  2'b01, 0, 1, 0, 0, 0, 16'd0);
    prog_a[1] = mk(1, 5'd5, 11'd3,  2'b10, 1, 1, 0, 0, 0, 16'd5);
    prog_a[2] = mk(2, 5'd1, 11'd10, 2'b00, 0, 0, 0, 1, 0, 16'd8);
    prog_a[3] = mk(3, 5'd7, 11'd1,  2'b10, 1, 1, 1, 0, 0, 16'd8);
    prog_a[4] = mk(4, 5'd0, 11'd0,  2'b00, 0, 0, 0, 0, 0, 16'd7);
    prog_b[0] = mk(0, 5'd2, 11'd3,  2'b00, 0, 1, 0, 0, 1, 16'd0);
    prog_b[1] = mk(1, 5'd4, 11'd3,  2'b10, 0, 1, 0, 0, 1, 16'd20);
    prog_b[2] = mk(2, 5'd6, 11'd3,  2'b10, 0, 1, 1, 0, 1, 16'd40);
    prog_b[3] = mk(3, 5'd0, 11'd0,  2'b00, 0, 0, 0, 0, 0, 16'd20);
    prog_d[0] = mk(0, 5'h1F, 11'd0, 2'b00, 0, 0, 0, 0, 0, 16'd0);
    prog_d[1] = mk(1, 5'd0, 11'd0,  2'b00, 0, 0, 0, 0, 0, 16'd0);

    for (int i = 0; i < 2048; i++) begin
      imem[i] = 16'h0000;
      dmem[i] = 16'h0000;
    end

    // Reset with non-zero program memory.
    for (int i = 0; i < 5; i++) imem[prog_a[i].pc] = prog_a[i].ins;
    w_rst = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rst_strobes0", {wracc, wrram, rdram}, 3'b000);
    @(negedge clk);
    chk("rst_strobes1", {wracc, wrram, rdram}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    w_rst = 1'b0;
    chk("rst_pc", 32'(pc), 0);
    chk("rst_state", {running, halted}, 2'b00);
    chk("rst_cnt", 32'(icnt), 0);
    for (int i = 0; i < 10; i++) @(negedge clk);
    chk("idle_pc_10cyc", 32'(pc), 0);
    chk("idle_strobes", {running, wracc, wrram, rdram}, 4'b0000);

    // Program A: LDI 5; ADDI 3; STO 10; SUBI 1; HLT.
    for (int i = 0; i < 5; i++) load(prog_a[i]);
    run_prog(20);
    chk("a_halted", 32'(halted), 1);
    chk("a_pc", 32'(pc), 4);
    chk("a_cnt", 32'(icnt), 4);
    chk("a_acc", 32'(acc), 7);
    chk("a_mem10", 32'(dmem[10]), 8);

    // HALT is sticky against i_start.
    for (int i = 0; i < 3; i++) begin
      pulse_start();
      @(negedge clk);
    end
    chk("halt_sticky", {halted, running}, 2'b10);
    chk("halt_pc", 32'(pc), 4);
    chk("halt_strobes", {wracc, wrram, rdram}, 3'b000);
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    chk("rst_start_idle", {running, halted}, 2'b00);
    chk("rst_start_pc", 32'(pc), 0);

    // Program B: memory operand ops.
    clear_imem();
    poke(11'd3, 16'd20);
    for (int i = 0; i < 4; i++) load(prog_b[i]);
    do_reset();
    run_prog(20);
    chk("b_acc", 32'(acc), 20);
    chk("b_cnt", 32'(icnt), 3);

    // Undefined opcode counts as a NOP.
    clear_imem();
    for (int i = 0; i < 2; i++) load(prog_d[i]);
    do_reset();
    run_prog(20);
    chk("d_pc", 32'(pc), 1);
    chk("d_cnt", 32'(icnt), 1);

    // Reset while STO is being decoded.
    clear_imem();
    for (int i = 0; i < 5; i++) imem[prog_a[i].pc] = prog_a[i].ins;
    do_reset();
    poke(11'd10, 16'd99);
    pulse_start();
    cyc = 0;
    while (pc != 11'd2 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_reach_pc2", 32'(pc), 2);
    rst = 1'b1;
    #1 chk("mid_wrram_gated", {wrram, wracc, rdram}, 3'b000);
    @(posedge clk);
    #1;
    chk("mid_pc0", 32'(pc), 0);
    chk("mid_idle", {running, halted}, 2'b00);
    chk("mid_mem10", 32'(dmem[10]), 99);
    @(negedge clk);
    rst = 1'b0;

    // PC wrap with a 3-bit program counter.
    w_start = 1'b1;
    @(negedge clk);
    w_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("wrap_pc_k%0d", k), {w_running, w_pc}, {1'b1, 3'(k % 8)});
      @(negedge clk);
    end
    chk("wrap_cnt", 32'(w_icnt), 10);
    chk("wrap_strobes", {w_wracc, w_wrram, w_rdram}, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bip_control.md
Name: bip_control

Overview:
- Single-cycle control unit for the accumulator datapath.
- Holds the program counter and fetches 16-bit instructions from program memory (5-bit opcode, 11-bit operand).
- Decodes each instruction in one cycle into datapath selects, accumulator write, add/subtract op, and data-memory read/write strobes.
- Run/halt FSM gates execution; an executed-instruction counter is provided for debug.

Parameters:
- NBITS_PC, 11, program counter / program-memory address width
- NBITS_OPC, 5, opcode width (instruction [15:11])
- NBITS_O, 11, operand width (instruction [10:0])
- NBITS_I, 16, instruction width (= NBITS_OPC + NBITS_O)
- NBITS_CNT, 16, executed-instruction counter width

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_start  in  1  one-cycle pulse; IDLE -> RUN
- i_Instruction  in  NBITS_I  program-memory word at o_PC (combinational read)
- o_PC  out  NBITS_PC  program-memory address
- o_Operand  out  NBITS_O  instruction [10:0]; to sign extension and data-memory address
- o_SelA  out  2  ACC source: 00 data memory, 01 extended immediate, 10 ALU, 11 unused
- o_SelB  out  1  ALU B operand: 0 data memory, 1 extended immediate
- o_WrAcc  out  1  accumulator write enable
- o_Op  out  1  ALU op: 0 add, 1 subtract
- o_WrRam  out  1  data-memory write (ACC -> mem[o_Operand])
- o_RdRam  out  1  data-memory read enable
- o_running  out  1  state == RUN
- o_halted  out  1  state == HALT
- o_instr_count  out  NBITS_CNT  executed non-HLT instructions, saturating

Behaviour:
- Reset is synchronous and active-high: on an edge with i_reset=1, PC=0, state=IDLE, o_instr_count=0.
- All strobes (o_WrAcc, o_WrRam, o_RdRam) are forced to 0 while i_reset=1 (same cycle), so no writes occur during the reset cycle.
- FSM states: IDLE, RUN, HALT.
  - IDLE: strobes 0, PC held. i_start=1 -> RUN.
  - RUN: one instruction per cycle. Decode is combinational from i_Instruction. Next edge: PC <= PC+1, unless opcode is HLT.
  - HLT in RUN: strobes 0, PC held at the HLT address, next state HALT, count unchanged.
  - HALT: sticky; i_start ignored; exit only via reset.
- i_start in RUN is ignored.
- Decode, active only in RUN; otherwise SelA=00, SelB=0, Op=0, strobes 0:
  - 00000 HLT: all strobes 0.
  - 00001 STO: WrRam=1.
  - 00010 LD: RdRam=1, SelA=00, WrAcc=1.
  - 00011 LDI: SelA=01, WrAcc=1.
  - 00100 ADD: RdRam=1, SelB=0, Op=0, SelA=10, WrAcc=1.
  - 00101 ADDI: SelB=1, Op=0, SelA=10, WrAcc=1.
  - 00110 SUB: RdRam=1, SelB=0, Op=1, SelA=10, WrAcc=1.
  - 00111 SUBI: SelB=1, Op=1, SelA=10, WrAcc=1.
  - Any other opcode: NOP. Strobes 0, PC increments, counted.
- o_Operand = i_Instruction[10:0] in every state; it is not gated.
- Latency: datapath effects of instruction at PC=k (ACC/memory write) land on the same edge where PC becomes k+1.
- The first instruction executes from PC=0 in the cycle after the i_start pulse.
- PC wraps 2^NBITS_PC-1 -> 0 with no halt.
- o_instr_count increments on every RUN edge with a non-HLT opcode; it saturates at all-ones.
- Simultaneous i_reset and i_start: reset wins; state=IDLE.

Test Plan:
- Reset: hold i_reset 2 cycles with program memory non-zero -> o_PC=0, IDLE, all strobes 0 during and after, o_instr_count=0; i_start absent -> PC stays 0 for 10 cycles.
- Program LDI 5; ADDI 3; STO 10; SUBI 1; HLT, pulse i_start:
  - o_PC runs 0,1,2,3,4 on consecutive cycles.
  - PC0: SelA=01, WrAcc=1.
  - PC1: SelA=10, SelB=1, Op=0.
  - PC2: WrRam=1, o_Operand=10.
  - PC3: Op=1.
  - Then o_halted=1, o_PC=4, o_instr_count=4, ACC=7, mem[10]=8.
- Memory ops: mem[3]=20, program LD 3; ADD 3; SUB 3; HLT -> RdRam=1 on PCs 0–2, SelB=0; ACC goes 20,40,20.
- HALT stickiness: after HLT, pulse i_start 3 times -> o_halted stays 1, PC unchanged, strobes 0; one reset cycle -> IDLE, PC=0.
- Undefined opcode 11111 at PC0, HLT at PC1 -> no strobes at PC0, PC advances to 1, o_instr_count=1.
- Mid-run reset: assert i_reset at PC=2 while STO is being decoded -> WrRam=0 in that cycle, mem[10] unchanged, next cycle PC=0, IDLE.
- Wrap: NBITS_PC=3, all NOPs -> PC 7 -> 0, still RUN.
